// File: rtl/ahblite_bus_matrix_decoder.sv
// AHB-Lite address decoder and slave-response multiplexer with a registered
// data-phase select, an internal two-cycle ERROR default slave and fault capture.
module ahblite_bus_matrix_decoder #(
   parameter int                         NUM_SLAVES = 6,
   parameter logic [32*NUM_SLAVES-1:0]   SLV_BASE   = {32'h40010000, 32'h40000000,
                                                       32'h40000010, 32'h40050000,
                                                       32'h20000000, 32'h00000000},
   parameter logic [32*NUM_SLAVES-1:0]   SLV_MASK   = {32'hFFFF0000, 32'hFFFFFFF0,
                                                       32'hFFFFFFF0, 32'hFFFF0000,
                                                       32'hFFFF0000, 32'hFFFF0000},
   parameter logic [NUM_SLAVES-1:0]      SLV_EN     = '1,
   parameter int                         CNT_W      = 8
) (
   input  logic                         HCLK,
   input  logic                         HRESET,
   input  logic [31:0]                  HADDR,
   input  logic [1:0]                   HTRANS,
   output logic                         HREADY,
   output logic [31:0]                  HRDATA,
   output logic                         HRESP,
   output logic [NUM_SLAVES-1:0]        S_HSEL,
   input  logic [NUM_SLAVES-1:0]        S_HREADYOUT,
   input  logic [32*NUM_SLAVES-1:0]     S_HRDATA,
   input  logic [NUM_SLAVES-1:0]        S_HRESP,
   input  logic                         ERR_CLR,
   output logic [CNT_W-1:0]             ERR_COUNT,
   output logic [31:0]                  ERR_ADDR,
   output logic                         ERR_IRQ
);

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   typedef enum logic [1:0] {SEL_NONE, SEL_SLOT, SEL_DEFAULT} sel_e;
   typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_e;

   logic [NUM_SLAVES-1:0] hit;
   logic                  anyHit;
   logic [IDX_W-1:0]      winIdx;
   logic                  errEntry;

   sel_e                  selKind_q, selKind_d;
   logic [IDX_W-1:0]      selIdx_q, selIdx_d;
   ds_e                   dsState_q, dsState_d;

   logic [CNT_W-1:0]      errCnt_q, errCnt_d;
   logic [31:0]           errAddr_q, errAddr_d;
   logic                  errIrq_q;

   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         hit[i] = SLV_EN[i] && ((HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]);
      end
   end

   // Scan from the top so the lowest-index hit is the last one written and wins.
   always_comb begin
      winIdx = '0;
      S_HSEL = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (hit[i]) begin
            winIdx    = IDX_W'(i);
            S_HSEL    = '0;
            S_HSEL[i] = 1'b1;
         end
      end
   end

   assign anyHit   = |hit;
   assign errEntry = HREADY && !anyHit && HTRANS[1];

   always_comb begin
      selKind_d = selKind_q;
      selIdx_d  = selIdx_q;
      if (HREADY) begin
         if (anyHit) begin
            selKind_d = SEL_SLOT;
            selIdx_d  = winIdx;
         end else if (HTRANS[1]) begin
            selKind_d = SEL_DEFAULT;
         end else begin
            selKind_d = SEL_NONE;
         end
      end
   end

   // ERR2 drives HREADY high, so a new unmapped transfer sampled there re-enters ERR1.
   always_comb begin
      dsState_d = dsState_q;
      case (dsState_q)
         DS_IDLE: if (errEntry) dsState_d = DS_ERR1;
         DS_ERR1: dsState_d = DS_ERR2;
         DS_ERR2: dsState_d = errEntry ? DS_ERR1 : DS_IDLE;
         default: dsState_d = DS_IDLE;
      endcase
   end

   always_comb begin
      HREADY = 1'b1;
      HRDATA = '0;
      HRESP  = 1'b0;
      case (selKind_q)
         SEL_SLOT: begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
               if (selIdx_q == IDX_W'(i)) begin
                  HREADY = S_HREADYOUT[i];
                  HRDATA = S_HRDATA[32*i +: 32];
                  HRESP  = S_HRESP[i];
               end
            end
         end
         SEL_DEFAULT: begin
            HREADY = (dsState_q == DS_ERR2);
            HRESP  = (dsState_q != DS_IDLE);
         end
         default: ;
      endcase
   end

   // A clear that coincides with a new error still records that error.
   always_comb begin
      errCnt_d  = errCnt_q;
      errAddr_d = errAddr_q;
      if (errEntry) begin
         errAddr_d = HADDR;
         if (ERR_CLR) begin
            errCnt_d = CNT_W'(1);
         end else if (errCnt_q != {CNT_W{1'b1}}) begin
            errCnt_d = errCnt_q + CNT_W'(1);
         end
      end else if (ERR_CLR) begin
         errCnt_d  = '0;
         errAddr_d = '0;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         selKind_q <= SEL_NONE;
         selIdx_q  <= '0;
         dsState_q <= DS_IDLE;
         errCnt_q  <= '0;
         errAddr_q <= '0;
         errIrq_q  <= 1'b0;
      end else begin
         selKind_q <= selKind_d;
         selIdx_q  <= selIdx_d;
         dsState_q <= dsState_d;
         errCnt_q  <= errCnt_d;
         errAddr_q <= errAddr_d;
         errIrq_q  <= errEntry;
      end
   end

   assign ERR_COUNT = errCnt_q;
   assign ERR_ADDR  = errAddr_q;
   assign ERR_IRQ   = errIrq_q;

endmodule

// File: tb/tb_ahblite_bus_matrix_decoder.sv
// Scoreboard bench: two decoder instances (default map, and slot 3 disabled with a
// 2-bit error counter) checked every cycle against a transfer-level reference model.
module tb_ahblite_bus_matrix_decoder;

   localparam int N   = 6;
   localparam int DEF = 100;

   logic            HCLK = 1'b1;
   logic            HRESET;
   logic [31:0]     HADDR;
   logic [1:0]      HTRANS;
   logic [N-1:0]    S_HREADYOUT;
   logic [32*N-1:0] S_HRDATA;
   logic [N-1:0]    S_HRESP;
   logic            ERR_CLR;

   logic [1:0]      hready;
   logic [31:0]     hrdata [2];
   logic [1:0]      hresp;
   logic [N-1:0]    hsel [2];
   logic [7:0]      cntA;
   logic [1:0]      cntB;
   logic [31:0]     eaddr [2];
   logic [1:0]      irq;

   int checks = 0;
   int errors = 0;

   logic [31:0] BASE [N] = '{32'h00000000, 32'h20000000, 32'h40050000,
                             32'h40000010, 32'h40000000, 32'h40010000};
   logic [31:0] MASK [N] = '{32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000,
                             32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFF0000};
   logic [N-1:0] enMask [2] = '{6'b111111, 6'b110111};
   int           cntMax [2] = '{255, 3};

   typedef struct {
      logic [N-1:0] hsel;
      logic         ready;
      logic [31:0]  rdata;
      logic         resp;
      int           cnt;
      logic [31:0]  addr;
      logic         irq;
   } exp_t;

   exp_t q0 [$];
   exp_t q1 [$];

   // Reference state: data-phase target (-1 none, slot, or DEF) and error cycles left.
   int          mTgt  [2];
   int          mLeft [2];
   int          mCnt  [2];
   logic [31:0] mAddr [2];
   logic        mIrq  [2];

   ahblite_bus_matrix_decoder dutA (
      .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
      .HREADY(hready[0]), .HRDATA(hrdata[0]), .HRESP(hresp[0]), .S_HSEL(hsel[0]),
      .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA), .S_HRESP(S_HRESP),
      .ERR_CLR(ERR_CLR), .ERR_COUNT(cntA), .ERR_ADDR(eaddr[0]), .ERR_IRQ(irq[0])
   );

   ahblite_bus_matrix_decoder #(.SLV_EN(6'b110111), .CNT_W(2)) dutB (
      .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
      .HREADY(hready[1]), .HRDATA(hrdata[1]), .HRESP(hresp[1]), .S_HSEL(hsel[1]),
      .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA), .S_HRESP(S_HRESP),
      .ERR_CLR(ERR_CLR), .ERR_COUNT(cntB), .ERR_ADDR(eaddr[1]), .ERR_IRQ(irq[1])
   );

   always #5 HCLK = ~HCLK;

   function automatic int decodeAddr(int d, logic [31:0] a);
      for (int i = 0; i < N; i++) begin
         if (enMask[d][i] && ((a & MASK[i]) == BASE[i])) return i;
      end
      return -1;
   endfunction

   function automatic void modelReset(int d);
      mTgt[d]  = -1;
      mLeft[d] = 0;
      mCnt[d]  = 0;
      mAddr[d] = 32'h0;
      mIrq[d]  = 1'b0;
   endfunction

   function automatic exp_t predict(int d);
      exp_t e;
      int   t;
      t      = decodeAddr(d, HADDR);
      e.hsel = (t >= 0) ? (N'(1) << t) : '0;
      if (mTgt[d] == DEF) begin
         e.ready = (mLeft[d] == 1);
         e.rdata = 32'h0;
         e.resp  = 1'b1;
      end else if (mTgt[d] >= 0) begin
         e.ready = S_HREADYOUT[mTgt[d]];
         e.rdata = S_HRDATA[32*mTgt[d] +: 32];
         e.resp  = S_HRESP[mTgt[d]];
      end else begin
         e.ready = 1'b1;
         e.rdata = 32'h0;
         e.resp  = 1'b0;
      end
      e.cnt  = mCnt[d];
      e.addr = mAddr[d];
      e.irq  = mIrq[d];
      return e;
   endfunction

   // Advance the model across one rising edge using the inputs held in that cycle.
   function automatic void modelStep(int d);
      exp_t e;
      int   t;
      if (HRESET) begin
         modelReset(d);
         return;
      end
      e       = predict(d);
      mIrq[d] = 1'b0;
      if (mTgt[d] == DEF && mLeft[d] == 2) mLeft[d] = 1;
      if (e.ready) begin
         t = decodeAddr(d, HADDR);
         if (t >= 0) begin
            mTgt[d] = t;
         end else if (HTRANS[1]) begin
            mTgt[d]  = DEF;
            mLeft[d] = 2;
            mIrq[d]  = 1'b1;
         end else begin
            mTgt[d] = -1;
         end
      end
      if (mIrq[d]) begin
         mAddr[d] = HADDR;
         mCnt[d]  = ERR_CLR ? 1 : ((mCnt[d] + 1 > cntMax[d]) ? cntMax[d] : mCnt[d] + 1);
      end else if (ERR_CLR) begin
         mCnt[d]  = 0;
         mAddr[d] = 32'h0;
      end
   endfunction

   task automatic applyStimulus(input logic [31:0] a, input logic [1:0] tr,
                                input logic [N-1:0] rdy, input logic clr, input logic rst);
      @(posedge HCLK);
      modelStep(0);
      modelStep(1);
      #1;
      HADDR       = a;
      HTRANS      = tr;
      S_HREADYOUT = rdy;
      ERR_CLR     = clr;
      HRESET      = rst;
      for (int i = 0; i < N; i++) begin
         S_HRDATA[32*i +: 32] = $urandom;
         S_HRESP[i]           = ($urandom_range(0, 19) == 0);
      end
      if (rst) begin
         modelReset(0);
         modelReset(1);
      end
      q0.push_back(predict(0));
      q1.push_back(predict(1));
   endtask

   task automatic cmp(input string name, input int d, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("[TB] FAIL %s dut%0d @%0t: got %h, expected %h", name, d, $time, act, want);
      end
   endtask

   task automatic checkOutput(input int d, input exp_t e);
      cmp("S_HSEL", d, 32'(hsel[d]), 32'(e.hsel));
      cmp("HREADY", d, 32'(hready[d]), 32'(e.ready));
      cmp("HRDATA", d, hrdata[d], e.rdata);
      cmp("HRESP", d, 32'(hresp[d]), 32'(e.resp));
      cmp("ERR_COUNT", d, (d == 0) ? 32'(cntA) : 32'(cntB), e.cnt);
      cmp("ERR_ADDR", d, eaddr[d], e.addr);
      cmp("ERR_IRQ", d, 32'(irq[d]), 32'(e.irq));
   endtask

   // Monitor: compares whatever the DUTs present against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge HCLK);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            checkOutput(0, e);
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            checkOutput(1, e);
         end
      end
   end

   initial begin
      logic [31:0] addrPool [10];
      logic [31:0] a;
      logic [N-1:0] rdy;
      addrPool = '{32'h20000004, 32'h40000014, 32'h40000004, 32'h30000000, 32'h00001234,
                   32'h40050008, 32'h40010000, 32'h4000001C, 32'h12345678, 32'h4000000C};

      HRESET = 1'b1; HADDR = '0; HTRANS = 2'b00; S_HREADYOUT = '1;
      S_HRDATA = '0; S_HRESP = '0; ERR_CLR = 1'b0;
      modelReset(0);
      modelReset(1);
      q0.push_back(predict(0));
      q1.push_back(predict(1));

      applyStimulus(32'h0, 2'b00, '1, 1'b0, 1'b1);
      applyStimulus(32'h0, 2'b00, '1, 1'b0, 1'b0);
      // Basic decode and slot read
      applyStimulus(32'h20000004, 2'b10, '1, 1'b0, 1'b0);
      applyStimulus(32'h40000014, 2'b10, '1, 1'b0, 1'b0);
      applyStimulus(32'h40000004, 2'b10, '1, 1'b0, 1'b0);
      applyStimulus(32'h0, 2'b00, '1, 1'b0, 1'b0);
      // Single error, then back-to-back errors, then IDLE to unmapped
      applyStimulus(32'h30000000, 2'b10, '1, 1'b0, 1'b0);
      repeat (3) applyStimulus(32'h0, 2'b00, '1, 1'b0, 1'b0);
      applyStimulus(32'h30000000, 2'b10, '1, 1'b0, 1'b0);
      applyStimulus(32'h30000004, 2'b11, '1, 1'b0, 1'b0);
      applyStimulus(32'h30000004, 2'b11, '1, 1'b0, 1'b0);
      repeat (3) applyStimulus(32'h0, 2'b00, '1, 1'b0, 1'b0);
      applyStimulus(32'h30000000, 2'b00, '1, 1'b0, 1'b0);
      applyStimulus(32'h0, 2'b00, '1, 1'b0, 1'b0);
      // Slot 0 wait states while the address moves to slot 1
      applyStimulus(32'h00000010, 2'b10, '1, 1'b0, 1'b0);
      repeat (3) applyStimulus(32'h20000000, 2'b10, 6'b111110, 1'b0, 1'b0);
      applyStimulus(32'h20000000, 2'b10, '1, 1'b0, 1'b0);
      applyStimulus(32'h0, 2'b00, '1, 1'b0, 1'b0);
      // Reset in the middle of ERR1
      applyStimulus(32'h30000000, 2'b10, '1, 1'b0, 1'b0);
      applyStimulus(32'h30000000, 2'b10, '1, 1'b0, 1'b1);
      applyStimulus(32'h0, 2'b00, '1, 1'b0, 1'b0);
      // Clear coinciding with a new error, then a standalone clear
      applyStimulus(32'h30000000, 2'b10, '1, 1'b0, 1'b0);
      repeat (2) applyStimulus(32'h0, 2'b00, '1, 1'b0, 1'b0);
      applyStimulus(32'h50000000, 2'b10, '1, 1'b1, 1'b0);
      repeat (2) applyStimulus(32'h0, 2'b00, '1, 1'b0, 1'b0);
      applyStimulus(32'h0, 2'b00, '1, 1'b1, 1'b0);
      applyStimulus(32'h0, 2'b00, '1, 1'b0, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 800; n++) begin
         a = addrPool[$urandom_range(0, 9)];
         if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) a = $urandom;
         for (int i = 0; i < N; i++) rdy[i] = ($urandom_range(0, 3) != 0);
         applyStimulus(a, 2'($urandom_range(0, 3)), rdy, ($urandom_range(0, 29) == 0),
                       ($urandom_range(0, 99) == 0));
      end

      // Continuous unmapped traffic drives both counters into saturation
      for (int n = 0; n < 600; n++) begin
         applyStimulus(32'h30000000 + 32'(4 * n), 2'b10, '1, 1'b0, 1'b0);
      end
      repeat (3) applyStimulus(32'h0, 2'b00, '1, 1'b0, 1'b0);

      @(negedge HCLK);
      @(negedge HCLK);
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", q0.size(), q1.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
